// File: rtl/mul_sequencer.sv
// Iterative radix-2 shift-add multiplier for MUL/UMULL/SMULL that drives the
// register-file write port (low word, then high word) and emits N/Z flags.
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             set_flags,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [3:0]       rd_lo,
  input  logic [3:0]       rd_hi,
  output logic             busy,
  output logic             done,
  output logic             wr_en,
  output logic [3:0]       wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             flags_we,
  output logic [1:0]       flags_nz
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [2:0] OP_MUL   = 3'b100;
  localparam logic [2:0] OP_UMULL = 3'b101;
  localparam logic [2:0] OP_SMULL = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_FIX, S_WB_LO, S_WB_HI, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic                 neg_q, neg_d;
  logic                 long_q, long_d;
  logic                 sf_q, sf_d;
  logic [3:0]           rd_lo_q, rd_lo_d;
  logic [3:0]           rd_hi_q, rd_hi_d;

  logic                 op_legal;
  logic                 is_smull;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       sum;

  assign op_legal = (op == OP_MUL) || (op == OP_UMULL) || (op == OP_SMULL);
  assign is_smull = (op == OP_SMULL);
  // Magnitude of the most negative value wraps to itself, which is the
  // correct unsigned magnitude.
  assign mag_a = (is_smull && src_a[WIDTH-1]) ? -src_a : src_a;
  assign mag_b = (is_smull && src_b[WIDTH-1]) ? -src_b : src_b;
  // Carry is kept in sum[WIDTH] and shifted back into the accumulator MSB.
  assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
               (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    long_d  = long_q;
    sf_d    = sf_q;
    rd_lo_d = rd_lo_q;
    rd_hi_d = rd_hi_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op_legal) begin
            mcand_d = mag_a;
            acc_d   = {{WIDTH{1'b0}}, mag_b};
            neg_d   = is_smull && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            long_d  = (op != OP_MUL);
            sf_d    = set_flags;
            rd_lo_d = rd_lo;
            rd_hi_d = rd_hi;
            cnt_d   = '0;
            state_d = S_CALC;
          end else begin
            sf_d    = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_CALC: begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        if (neg_q) acc_d = -acc_q;
        state_d = S_WB_LO;
      end
      S_WB_LO: state_d = long_q ? S_WB_HI : S_DONE;
      S_WB_HI: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      long_q  <= 1'b0;
      sf_q    <= 1'b0;
      rd_lo_q <= '0;
      rd_hi_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      long_q  <= long_d;
      sf_q    <= sf_d;
      rd_lo_q <= rd_lo_d;
      rd_hi_q <= rd_hi_d;
    end
  end

  // Outputs are pure decodes of registered state.
  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    wr_en    = 1'b0;
    wr_addr  = 4'd0;
    wr_data  = '0;
    flags_we = 1'b0;
    flags_nz = 2'b00;
    case (state_q)
      S_WB_LO: begin
        wr_en   = 1'b1;
        wr_addr = rd_lo_q;
        wr_data = acc_q[WIDTH-1:0];
      end
      S_WB_HI: begin
        wr_en   = 1'b1;
        wr_addr = rd_hi_q;
        wr_data = acc_q[2*WIDTH-1:WIDTH];
      end
      S_DONE: begin
        if (sf_q) begin
          flags_we = 1'b1;
          if (long_q) flags_nz = {acc_q[2*WIDTH-1], acc_q == '0};
          else        flags_nz = {acc_q[WIDTH-1], acc_q[WIDTH-1:0] == '0};
        end
      end
      default: ;
    endcase
  end

endmodule
